// File: rtl/display_update_scheduler_pkg.sv
// Shared types and widths for the frame-synchronous display update scheduler.
package display_update_scheduler_pkg;
    localparam int LOC_W            = 12;
    localparam int ORI_W            = 4;
    localparam int MOVE_W           = 12;
    localparam int STALE_FRAMES_DEF = 30;
    localparam int CNT_W_DEF        = 8;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;
endpackage

// File: rtl/display_update_scheduler_if.sv
// Valid/ready links from the location producer and the orientation/move producer.
interface display_update_scheduler_if;
    import display_update_scheduler_pkg::*;

    logic              loc_valid;
    logic [LOC_W-1:0]  loc_data;
    logic              loc_ready;
    logic              ori_valid;
    logic [ORI_W-1:0]  ori_data;
    logic [MOVE_W-1:0] ori_move;
    logic              ori_ready;

    modport master (output loc_valid, loc_data, ori_valid, ori_data, ori_move,
                    input  loc_ready, ori_ready);
    modport slave  (input  loc_valid, loc_data, ori_valid, ori_data, ori_move,
                    output loc_ready, ori_ready);
endinterface

// File: rtl/display_update_scheduler_update_slot.sv
// One-entry pending register: latest accept wins, cleared when the frame commits.
module update_slot #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         accept,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] data,
    output logic         pending,
    output logic         overwrite
);
    logic [W-1:0] data_q, data_d;
    logic         pending_q, pending_d;

    always_comb begin
        data_d    = data_q;
        pending_d = pending_q;
        if (clear)  pending_d = 1'b0;
        if (accept) begin
            data_d    = din;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    assign data      = data_q;
    assign pending   = pending_q;
    assign overwrite = accept & pending_q;
endmodule

// File: rtl/display_update_scheduler.sv
// Buffers the latest location and orientation requests and commits them together
// at vsync start so the display writer never sees a mid-frame change.
module display_update_scheduler
    import display_update_scheduler_pkg::*;
#(
    parameter int STALE_FRAMES = STALE_FRAMES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vsync,
    display_update_scheduler_if.slave  req,
    output logic [LOC_W-1:0]           location,
    output logic [ORI_W-1:0]           orientation,
    output logic [MOVE_W-1:0]          move_command,
    output logic                       new_data,
    output logic                       orientation_ready,
    output logic                       stale,
    output logic [CNT_W-1:0]           drop_count
);
    state_t             state_q, state_d;
    logic               vsync_d_q;
    logic [LOC_W-1:0]   location_q, location_d;
    logic [ORI_W-1:0]   orientation_q, orientation_d;
    logic [MOVE_W-1:0]  move_q, move_d;
    logic               new_data_q, new_data_d;
    logic               ori_rdy_q, ori_rdy_d;
    logic               stale_q, stale_d;
    logic [CNT_W-1:0]   age_q, age_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W:0]     drop_sum;

    logic               vs_start, ready, commit;
    logic [LOC_W-1:0]   loc_slot;
    logic [ORI_W+MOVE_W-1:0] ori_slot;
    logic               loc_pend, ori_pend, loc_ovw, ori_ovw;

    assign vs_start      = vsync_d_q & ~vsync;
    assign ready         = (state_q == ST_ACTIVE);
    assign commit        = (state_q == ST_COMMIT);
    assign req.loc_ready = ready;
    assign req.ori_ready = ready;

    update_slot #(.W(LOC_W)) u_loc_slot (
        .clk(clk), .reset(reset), .accept(req.loc_valid & ready), .clear(commit),
        .din(req.loc_data), .data(loc_slot), .pending(loc_pend), .overwrite(loc_ovw)
    );

    update_slot #(.W(ORI_W+MOVE_W)) u_ori_slot (
        .clk(clk), .reset(reset), .accept(req.ori_valid & ready), .clear(commit),
        .din({req.ori_data, req.ori_move}), .data(ori_slot), .pending(ori_pend),
        .overwrite(ori_ovw)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if (vs_start) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
    end

    // Both slots can overwrite in the same cycle, so the counter may step by two.
    assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'({1'b0, loc_ovw} + {1'b0, ori_ovw});

    always_comb begin
        location_d    = location_q;
        orientation_d = orientation_q;
        move_d        = move_q;
        new_data_d    = new_data_q;
        ori_rdy_d     = ori_rdy_q;
        age_d         = age_q;
        stale_d       = stale_q;
        drop_d        = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        if (commit) begin
            if (loc_pend) begin
                location_d = loc_slot;
                new_data_d = 1'b1;
                age_d      = '0;
            end else begin
                new_data_d = 1'b0;
                if (age_q < CNT_W'(STALE_FRAMES)) age_d = age_q + 1'b1;
            end
            if (ori_pend) begin
                {orientation_d, move_d} = ori_slot;
                ori_rdy_d = 1'b1;
            end else if (loc_pend) begin
                ori_rdy_d = 1'b0;
            end
            stale_d = (age_d >= CNT_W'(STALE_FRAMES));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ACTIVE;
            vsync_d_q     <= 1'b0;
            location_q    <= '0;
            orientation_q <= '0;
            move_q        <= '0;
            new_data_q    <= 1'b0;
            ori_rdy_q     <= 1'b0;
            stale_q       <= 1'b1;
            age_q         <= CNT_W'(STALE_FRAMES);
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            vsync_d_q     <= vsync;
            location_q    <= location_d;
            orientation_q <= orientation_d;
            move_q        <= move_d;
            new_data_q    <= new_data_d;
            ori_rdy_q     <= ori_rdy_d;
            stale_q       <= stale_d;
            age_q         <= age_d;
            drop_q        <= drop_d;
        end
    end

    assign location          = location_q;
    assign orientation       = orientation_q;
    assign move_command      = move_q;
    assign new_data          = new_data_q;
    assign orientation_ready = ori_rdy_q;
    assign stale             = stale_q;
    assign drop_count        = drop_q;
endmodule

// File: tb/tb_display_update_scheduler.sv
// Scoreboard bench: a behavioural model predicts each frame commit, checked when visible.
module tb_display_update_scheduler;
    localparam int STALE = 30;

    typedef struct {
        logic [11:0] loc;
        logic [3:0]  ori;
        logic [11:0] mv;
        logic        nd;
        logic        ordy;
        logic        stale;
        logic [7:0]  drop;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b1;
    logic [11:0] location;
    logic [3:0]  orientation;
    logic [11:0] move_command;
    logic        new_data, orientation_ready, stale;
    logic [7:0]  drop_count;

    display_update_scheduler_if bus();

    display_update_scheduler #(.STALE_FRAMES(STALE), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .req(bus),
        .location(location), .orientation(orientation), .move_command(move_command),
        .new_data(new_data), .orientation_ready(orientation_ready), .stale(stale),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    // model state
    exp_t        m;
    int          m_age;
    logic        p_loc, p_ori;
    logic [11:0] pv_loc, pv_mv;
    logic [3:0]  pv_ori;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, "_loc"},   location, e.loc);
        chk({tag, "_ori"},   orientation, e.ori);
        chk({tag, "_move"},  move_command, e.mv);
        chk({tag, "_nd"},    new_data, e.nd);
        chk({tag, "_ordy"},  orientation_ready, e.ordy);
        chk({tag, "_stale"}, stale, e.stale);
        chk({tag, "_drop"},  drop_count, e.drop);
    endtask

    task automatic model_reset();
        m = '{loc: 12'h0, ori: 4'h0, mv: 12'h0, nd: 1'b0, ordy: 1'b0, stale: 1'b1, drop: 8'h0};
        m_age = STALE;
        p_loc = 1'b0;
        p_ori = 1'b0;
    endtask

    task automatic model_drop();
        if (m.drop != 8'hFF) m.drop = m.drop + 8'h1;
    endtask

    task automatic model_commit();
        if (p_loc) begin
            m.loc = pv_loc; m.nd = 1'b1; m_age = 0;
        end else begin
            m.nd = 1'b0;
            if (m_age < STALE) m_age++;
        end
        if (p_ori) begin
            m.ori = pv_ori; m.mv = pv_mv; m.ordy = 1'b1;
        end else if (p_loc) begin
            m.ordy = 1'b0;
        end
        m.stale = (m_age >= STALE);
        p_loc = 1'b0;
        p_ori = 1'b0;
    endtask

    // handshake helpers start and end 1 time unit after a rising edge
    task automatic send(input logic do_loc, input logic [11:0] l,
                        input logic do_ori, input logic [3:0] o, input logic [11:0] mv);
        logic done = 1'b0;
        bus.loc_valid = do_loc; bus.loc_data = l;
        bus.ori_valid = do_ori; bus.ori_data = o; bus.ori_move = mv;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.loc_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
                if (do_loc) begin
                    if (p_loc) model_drop();
                    p_loc = 1'b1; pv_loc = l;
                end
                if (do_ori) begin
                    if (p_ori) model_drop();
                    p_ori = 1'b1; pv_ori = o; pv_mv = mv;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) chk("ready_timeout", bus.loc_ready, 1);
        bus.loc_valid = 1'b0;
        bus.ori_valid = 1'b0;
    endtask

    task automatic vs_fall();
        exp_t pre;
        pre = m;
        vsync = 1'b0;
        model_commit();
        sb.push_back(m);
        @(posedge clk); #1;
        chk("commit_loc_rdy", bus.loc_ready, 0);
        chk("commit_ori_rdy", bus.ori_ready, 0);
        chk("commit_hold_loc", location, pre.loc);
        chk("commit_hold_nd", new_data, pre.nd);
    endtask

    task automatic vs_rise();
        exp_t e;
        e = sb.pop_front();
        cmp_out("vis", e);
        vsync = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("frame_nd", new_data, e.nd);
        chk("frame_loc", location, e.loc);
    endtask

    task automatic frame();
        vs_fall();
        @(posedge clk); #1;
        vs_rise();
    endtask

    initial begin
        bus.loc_valid = 1'b0; bus.loc_data = '0;
        bus.ori_valid = 1'b0; bus.ori_data = '0; bus.ori_move = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cmp_out("rst", m);
        repeat (2) @(posedge clk);
        #1;

        // idle frames: age saturates, stale stays high
        for (int f = 0; f < 40; f++) frame();

        // location mid-frame, then a quiet frame drops new_data
        send(1'b1, 12'h2A5, 1'b0, 4'h0, 12'h0);
        frame();
        frame();

        // same-cycle location and orientation
        send(1'b1, 12'h123, 1'b1, 4'h6, 12'h0F0);
        frame();

        // three locations in one frame: latest wins, two drops, no orientation
        send(1'b1, 12'h001, 1'b0, 4'h0, 12'h0);
        send(1'b1, 12'h002, 1'b0, 4'h0, 12'h0);
        send(1'b1, 12'h003, 1'b0, 4'h0, 12'h0);
        frame();

        // orientation alone
        send(1'b0, 12'h0, 1'b1, 4'hA, 12'h5C3);
        frame();

        // location offered on the commit cycle waits for the next frame
        vs_fall();
        bus.loc_valid = 1'b1; bus.loc_data = 12'h777;
        @(posedge clk); #1;
        chk("commit_cycle_loc", location, 12'h003);
        bus.loc_valid = 1'b1;
        @(posedge clk); #1;
        p_loc = 1'b1; pv_loc = 12'h777;
        bus.loc_valid = 1'b0;
        vs_rise();
        frame();

        // reset with both slots pending right before vsync
        send(1'b1, 12'h555, 1'b1, 4'h3, 12'h0AA);
        reset = 1'b1;
        vsync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp_out("rst_vs", m);
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp_out("rst_after", m);
        frame();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
